uart_transmitter_txd: RTL and testbench
=======================================

Name: uart_transmitter_txd

Overview:
- 8N1 UART transmitter: the upstream partner of the team's UART receiver, driving the serial line that the receiver samples.
- Accepts one byte per valid/ready handshake and serialises it on TxD as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1).
- Default timing is 50 MHz / 9600 baud, so the receiver's 4x-oversampled mid-bit sampling sees stable bits.

Parameters:
- clk_freq, 50_000_000, system clock frequency in Hz
- baudrate, 9_600, line rate in bits/s
- bit_cycles, clk_freq/baudrate (5208 at defaults), clocks per serial bit; must be >= 2; counter width = clog2(bit_cycles)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- tx_data  input  8  byte to send; sampled only on an accepting edge
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a byte; combinational, high iff state==IDLE
- TxD  output  1  serial line, registered; idle level 1
- tx_busy  output  1  registered, high while a frame is on the line (START..STOP)
- tx_done  output  1  registered one-cycle pulse after the stop bit completes

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, TxD=1, tx_busy=0, tx_done=0, bit/baud counters=0, shift register=0.
- Reset has priority over everything. Reset mid-frame aborts the frame: TxD=1 from the next cycle; no tx_done.
- States: IDLE, START, DATA, STOP, with a baud counter 0..bit_cycles-1 and a bit index 0..7.
- IDLE:
  - TxD=1.
  - Accept = tx_valid & tx_ready at edge T: latch tx_data into the shift register, clear the baud counter, set tx_busy, go to START.
  - tx_valid without ready is ignored; the source holds the data.
- START: TxD=0 for exactly bit_cycles clocks, then DATA with bit index 0.
- DATA:
  - TxD = shift register bit 0.
  - After bit_cycles clocks, shift right by 1 and increment the bit index.
  - After bit index 7 completes, go to STOP.
- STOP: TxD=1 for bit_cycles clocks, then go to IDLE, clear tx_busy, and pulse tx_done for one cycle.
- Frame timing, with accept at edge T and B=bit_cycles:
  - start bit occupies cycles T+1..T+B
  - data bit i occupies cycles T+1+(i+1)B..T+(i+2)B
  - stop bit occupies cycles T+1+9B..T+10B
  - tx_done is high, and tx_ready is high, in cycle T+10B+1
- Back-to-back:
  - The earliest next accept is edge T+10B+1, so there is a minimum of 10B+1 clocks between accepts.
  - TxD stays 1 between frames; no glitches.
- Data stability: tx_data changes during a frame do not affect the frame in flight.
- Baud counter compares against bit_cycles-1 and wraps to 0, so there is no cumulative drift. Each bit is exactly B clocks.
- tx_ready is 0 in START/DATA/STOP, including the final STOP cycle; there is no accept-on-done overlap.
- tx_busy and tx_done are never high in the same cycle.

Test Plan:
1. Reset then idle (bit_cycles=10): hold reset 3 cycles, tx_valid=0 -> TxD=1, tx_ready=1, tx_busy=0, tx_done=0 for 50 cycles.
2. Single byte 0xA5, bit_cycles=10 -> TxD sequence per 10-cycle bit: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). tx_done pulses exactly once, at cycle T+101. tx_busy is high for cycles T+1..T+100.
3. Loopback at defaults: TxD wired to the UART receiver, send 0x3C then 0xFF -> receiver data output reads 0x3C, then 0xFF after each frame; no framing error; each bit is 5208 clocks.
4. Back-to-back with tx_valid held high and tx_data=0x00 then 0x81 -> second accept occurs exactly 101 cycles after the first (bit_cycles=10). No extra idle bits; TxD stays high in the gap cycle.
5. Data change mid-frame: send 0x55, then change tx_data to 0xAA while tx_valid=1 during DATA -> transmitted bits still encode 0x55. 0xAA is accepted only when tx_ready returns.
6. Reset mid-frame: assert reset during data bit 3 of 0xF0 -> TxD=1 the next cycle, no tx_done, tx_ready=1 after reset deasserts. A following byte 0x12 transmits correctly.

Source files
------------

// File: rtl/uart_transmitter_txd.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, serialised on TxD
// as start bit, 8 data bits LSB first, stop bit; each bit lasts bit_cycles clocks.
module uart_transmitter_txd #(
  parameter int unsigned clk_freq   = 50_000_000,
  parameter int unsigned baudrate   = 9_600,
  parameter int unsigned bit_cycles = clk_freq / baudrate
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxD,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_q,  baud_d;
  logic [IDX_W-1:0]   bit_q,   bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q,   txd_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               bit_end;

  assign bit_end  = (baud_q == CNT_W'(bit_cycles - 1));
  assign tx_ready = (state_q == IDLE);
  assign TxD      = txd_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; the baud counter wraps at bit_cycles-1 so bits never drift.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == IDX_W'(7)) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + IDX_W'(1);
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level and busy flag follow the state being entered, keeping TxD registered.
  always_comb begin
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter_txd.sv
// Directed bench for uart_transmitter_txd at bit_cycles=10: per-cycle frame
// checks plus a mid-bit decoder feeding a scoreboard of accepted bytes.
`timescale 1ns/1ps
module tb_uart_transmitter_txd;

  localparam int unsigned B      = 10;
  localparam int unsigned PERIOD = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       TxD;
  logic       tx_busy;
  logic       tx_done;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  time        t_a, t_b;

  uart_transmitter_txd #(
    .clk_freq  (50_000_000),
    .baudrate  (9_600),
    .bit_cycles(B)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TxD     (TxD),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #(PERIOD/2) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present the byte, wait for ready, return time of accepting edge.
  task automatic do_accept(input logic [7:0] d, output time t_acc);
    int n;
    n        = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    t_acc = $time;
    exp_q.push_back(d);
  endtask

  // Checks every cycle of the frame against the expected byte, then the done cycle.
  task automatic check_frame(input logic drop, input int chg_k, input logic [7:0] chg_d);
    logic [9:0] frame;
    logic [7:0] rx;
    logic [7:0] exp;
    int         j;
    rx    = 8'h00;
    exp   = exp_q[0];
    frame = {1'b1, exp, 1'b0};
    for (int k = 1; k <= int'(10 * B); k++) begin
      @(negedge clk);
      if (k == 1 && drop) tx_valid = 1'b0;
      if (k == chg_k) begin
        tx_data  = chg_d;
        tx_valid = 1'b1;
      end
      j = (k - 1) / int'(B);
      chk("txd_bit",   32'(TxD),      32'(frame[j]));
      chk("busy_in",   32'(tx_busy),  32'd1);
      chk("done_in",   32'(tx_done),  32'd0);
      chk("ready_in",  32'(tx_ready), 32'd0);
      if ((k - 1) % int'(B) == int'(B / 2) && j >= 1 && j <= 8) rx[j-1] = TxD;
    end
    @(negedge clk);
    chk("done_pulse", 32'(tx_done),  32'd1);
    chk("ready_done", 32'(tx_ready), 32'd1);
    chk("busy_done",  32'(tx_busy),  32'd0);
    chk("txd_done",   32'(TxD),      32'd1);
    chk("rx_byte",    32'(rx),       32'(exp_q.pop_front()));
  endtask

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd",  32'(TxD),     32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_txd",   32'(TxD),      32'd1);
      chk("idle_ready", 32'(tx_ready), 32'd1);
      chk("idle_busy",  32'(tx_busy),  32'd0);
      chk("idle_done",  32'(tx_done),  32'd0);
    end

    // Single byte 0xA5
    do_accept(8'hA5, t_a);
    check_frame(1'b1, 0, 8'h00);

    // Two frames decoded by the mid-bit receiver
    repeat (4) @(negedge clk);
    do_accept(8'h3C, t_a);
    check_frame(1'b1, 0, 8'h00);
    do_accept(8'hFF, t_a);
    check_frame(1'b1, 0, 8'h00);

    // Back-to-back with tx_valid held high
    repeat (5) @(negedge clk);
    do_accept(8'h00, t_a);
    check_frame(1'b0, 1, 8'h81);
    do_accept(8'h81, t_b);
    chk("b2b_gap", 32'((t_b - t_a) / PERIOD), 32'(10 * B + 1));
    check_frame(1'b1, 0, 8'h00);

    // Data change mid-frame does not disturb the byte in flight
    repeat (3) @(negedge clk);
    do_accept(8'h55, t_a);
    check_frame(1'b1, int'(2 * B + 3), 8'hAA);
    do_accept(8'hAA, t_b);
    chk("chg_gap", 32'((t_b - t_a) / PERIOD), 32'(10 * B + 1));
    check_frame(1'b1, 0, 8'h00);

    // Reset during data bit 3 of 0xF0 aborts the frame
    repeat (3) @(negedge clk);
    do_accept(8'hF0, t_a);
    for (int k = 1; k <= int'(4 * B + 5); k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
    end
    chk("abort_bit3", 32'(TxD), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_txd",   32'(TxD),      32'd1);
    chk("abort_busy",  32'(tx_busy),  32'd0);
    chk("abort_done",  32'(tx_done),  32'd0);
    chk("abort_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_front());
    for (int i = 0; i < int'(12 * B); i++) begin
      @(negedge clk);
      chk("post_abort_done",  32'(tx_done),  32'd0);
      chk("post_abort_txd",   32'(TxD),      32'd1);
      chk("post_abort_ready", 32'(tx_ready), 32'd1);
    end
    do_accept(8'h12, t_a);
    check_frame(1'b1, 0, 8'h00);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
